trap_commit_unit: RTL

//  Consumes the ExceptStruct::ExceptPack leaving the MEM/WB exception register and commits traps.

---
 rtl/trap_commit_unit_pkg.sv | 31 +++
 rtl/trap_csr_file.sv | 123 ++++++++++++
 rtl/trap_commit_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/trap_commit_unit_pkg.sv
// Shared types for the writeback trap commit logic: the exception pack carried
// down the pipeline and the CSR map / FSM encoding of the trap unit.
package ExceptStruct;
    localparam int EXC_XLEN = 64;

    typedef struct packed {
        logic                except;
        logic [EXC_XLEN-1:0] epc;
        logic [EXC_XLEN-1:0] ecause;
        logic [EXC_XLEN-1:0] etval;
    } ExceptPack;
endpackage

package TrapPkg;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [1:0] {IDLE, TRAP, RET} trap_state_t;
endpackage

// File: rtl/trap_csr_file.sv
// M-mode trap CSRs and privilege level; exposes next-state values so the
// redirect target can be registered in the same edge as the CSR update.
module trap_csr_file
    import TrapPkg::*;
    import ExceptStruct::*;
#(
    parameter int         XLEN     = 64,
    parameter logic [1:0] RST_PRIV = PRIV_M
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_trap,
    input  logic            i_ret,
    input  logic            i_wr,
    input  ExceptPack       i_except,
    input  logic [11:0]     i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_rdata,
    output logic [XLEN-1:0] o_mtvec_nxt,
    output logic [XLEN-1:0] o_mepc_nxt,
    output logic [XLEN-1:0] o_mcause_nxt,
    output logic [1:0]      o_priv
);
    logic            r_mie, r_mpie;
    logic [1:0]      r_mpp, r_priv;
    logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;

    logic            w_mie_nxt, w_mpie_nxt;
    logic [1:0]      w_mpp_nxt, w_priv_nxt;
    logic [XLEN-1:0] w_mtvec_nxt, w_mscratch_nxt, w_mepc_nxt, w_mcause_nxt, w_mtval_nxt;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_mie_nxt      = r_mie;
        w_mpie_nxt     = r_mpie;
        w_mpp_nxt      = r_mpp;
        w_priv_nxt     = r_priv;
        w_mtvec_nxt    = r_mtvec;
        w_mscratch_nxt = r_mscratch;
        w_mepc_nxt     = r_mepc;
        w_mcause_nxt   = r_mcause;
        w_mtval_nxt    = r_mtval;
        if (i_trap) begin
            w_mepc_nxt   = {i_except.epc[XLEN-1:1], 1'b0};
            w_mcause_nxt = i_except.ecause;
            w_mtval_nxt  = i_except.etval;
            w_mpie_nxt   = r_mie;
            w_mie_nxt    = 1'b0;
            w_mpp_nxt    = r_priv;
            w_priv_nxt   = PRIV_M;
        end else begin
            if (i_wr) begin
                case (i_addr)
                    CSR_MSTATUS: begin
                        w_mie_nxt  = i_wdata[MSTATUS_MIE];
                        w_mpie_nxt = i_wdata[MSTATUS_MPIE];
                        w_mpp_nxt  = i_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
                    end
                    CSR_MTVEC:    w_mtvec_nxt    = i_wdata;
                    CSR_MSCRATCH: w_mscratch_nxt = i_wdata;
                    CSR_MEPC:     w_mepc_nxt     = {i_wdata[XLEN-1:1], 1'b0};
                    CSR_MCAUSE:   w_mcause_nxt   = i_wdata;
                    CSR_MTVAL:    w_mtval_nxt    = i_wdata;
                    default: ;
                endcase
            end
            // mret sees the values the same instruction just wrote.
            if (i_ret) begin
                w_mie_nxt  = w_mpie_nxt;
                w_mpie_nxt = 1'b1;
                w_priv_nxt = w_mpp_nxt;
                w_mpp_nxt  = PRIV_U;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mpp      <= PRIV_U;
            r_priv     <= RST_PRIV;
            r_mtvec    <= '0;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
        end else begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            r_mie      <= w_mie_nxt;
            r_mpie     <= w_mpie_nxt;
            r_mpp      <= w_mpp_nxt;
            r_priv     <= w_priv_nxt;
            r_mtvec    <= w_mtvec_nxt;
            r_mscratch <= w_mscratch_nxt;
            r_mepc     <= w_mepc_nxt;
            r_mcause   <= w_mcause_nxt;
            r_mtval    <= w_mtval_nxt;
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_addr)
            CSR_MSTATUS: begin
                o_rdata[MSTATUS_MIE]                   = r_mie;
                o_rdata[MSTATUS_MPIE]                  = r_mpie;
                o_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = r_mpp;
            end
            CSR_MTVEC:    o_rdata = r_mtvec;
            CSR_MSCRATCH: o_rdata = r_mscratch;
            CSR_MEPC:     o_rdata = r_mepc;
            CSR_MCAUSE:   o_rdata = r_mcause;
            CSR_MTVAL:    o_rdata = r_mtval;
            default: ;
        endcase
    end

    assign o_mtvec_nxt  = w_mtvec_nxt;
    assign o_mepc_nxt   = w_mepc_nxt;
    assign o_mcause_nxt = w_mcause_nxt;
    assign o_priv       = r_priv;
endmodule

// File: rtl/trap_commit_unit.sv
// Writeback trap commit: qualifies trap/mret/CSR-write events, owns the
// IDLE/TRAP/RET sequencer and issues the one-cycle flush + fetch redirect.
module trap_commit_unit
    import TrapPkg::*;
    import ExceptStruct::*;
#(
    parameter int         XLEN     = 64,
    parameter logic [1:0] RST_PRIV = 2'b11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid_i,
    input  ExceptPack       except_i,
    input  logic            mret_i,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            flush_o,
    output logic            stall_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [1:0]      priv_o
);
    trap_state_t     r_state;
    logic            r_flush, r_stall, r_redirect;
    logic [XLEN-1:0] r_redirect_pc;

    logic            w_idle, w_trap, w_ret, w_wr;
    logic [XLEN-1:0] w_mtvec_nxt, w_mepc_nxt, w_mcause_nxt;
    logic [XLEN-1:0] w_trap_pc;

    // The WB slot is already being flushed outside IDLE, so its inputs are dropped.
    assign w_idle = (r_state == IDLE);
    assign w_trap = w_idle & wb_valid_i & except_i.except;
    assign w_ret  = w_idle & wb_valid_i & mret_i   & ~except_i.except;
    assign w_wr   = w_idle & wb_valid_i & csr_we_i & ~except_i.except;

    trap_csr_file #(
        .XLEN     (XLEN),
        .RST_PRIV (RST_PRIV)
    ) u_csr (
        .clk          (clk),
        .rst          (rst),
        .i_trap       (w_trap),
        .i_ret        (w_ret),
        .i_wr         (w_wr),
        .i_except     (except_i),
        .i_addr       (csr_addr_i),
        .i_wdata      (csr_wdata_i),
        .o_rdata      (csr_rdata_o),
        .o_mtvec_nxt  (w_mtvec_nxt),
        .o_mepc_nxt   (w_mepc_nxt),
        .o_mcause_nxt (w_mcause_nxt),
        .o_priv       (priv_o)
    );

    // Vectored mode offsets interrupts only; mode 1x falls back to direct.
    always_comb begin
        w_trap_pc = {w_mtvec_nxt[XLEN-1:2], 2'b00};
        if (w_mtvec_nxt[1:0] == 2'b01 && w_mcause_nxt[XLEN-1])
            w_trap_pc = {w_mtvec_nxt[XLEN-1:2], 2'b00} + {w_mcause_nxt[XLEN-3:0], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_flush       <= 1'b0;
            r_stall       <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_flush       <= 1'b0;
            r_stall       <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            case (r_state)
                IDLE: begin
                    if (w_trap) begin
                        r_state       <= TRAP;
                        r_flush       <= 1'b1;
                        r_stall       <= 1'b1;
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= w_trap_pc;
                    end else if (w_ret) begin
                        r_state       <= RET;
                        r_flush       <= 1'b1;
                        r_stall       <= 1'b1;
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= w_mepc_nxt;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign flush_o       = r_flush;
    assign stall_o       = r_stall;
    assign redirect_o    = r_redirect;
    assign redirect_pc_o = r_redirect_pc;
endmodule
